// File: rtl/sq_arb_pkg.sv
// Shared types, widths and the round-robin pick helper for the square arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sq_arb_pkg;

    localparam int SQ_IN_W  = 3;
    localparam int SQ_OUT_W = 6;
    localparam int MAX_REQ  = 8;
    localparam int PTR_W    = 3;

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_t;

    // First set bit of valid_vec at or after ptr, wrapping at num_req.
    // Scanned from the far end so the nearest candidate is assigned last.
    // Returns ptr when nothing is valid; callers gate on "any valid".
    function automatic int rr_pick(input logic [MAX_REQ-1:0] valid_vec,
                                   input int ptr,
                                   input int num_req);
        int idx;
        rr_pick = ptr;
        for (int k = num_req - 1; k >= 0; k--) begin
            idx = ptr + k;
            if (idx >= num_req) begin
                idx = idx - num_req;
            end
            if (valid_vec[idx[PTR_W-1:0]]) begin
                rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/squares_3bit.sv
// Combinational 3-bit squarer, full 6-bit product (max 49).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; output follows input.
module squares_3bit
    import sq_arb_pkg::*;
(
    input  logic [SQ_IN_W-1:0]  a,
    output logic [SQ_OUT_W-1:0] sq
);

    assign sq = {3'b000, a} * {3'b000, a};

endmodule

// File: rtl/square_share_arbiter.sv
// Round-robin shares one 3-bit squarer among NUM_REQ valid/ready requesters.
// Latency: 1 cycle from accept edge to res_valid; 1 result/cycle when res_ready held high.
// Backpressure: res_ready low holds the result register and withholds every req_ready.
module square_share_arbiter
    import sq_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [SQ_IN_W*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        res_valid,
    output logic [SQ_OUT_W-1:0]         res_data,
    output logic [ID_W-1:0]             res_id,
    input  logic                        res_ready
);

    state_t                 state;
    logic [ID_W-1:0]        rr_ptr;
    logic [ID_W-1:0]        grant;
    logic [ID_W-1:0]        ptr_nxt;
    logic [MAX_REQ-1:0]     vld_ext;
    logic [SQ_IN_W-1:0]     sq_in;
    logic [SQ_OUT_W-1:0]    sq_out;
    logic                   can_accept;
    logic                   any_vld;
    logic                   accept;

    // Output register is free when empty or draining this very cycle.
    assign can_accept = !res_valid || res_ready;
    assign any_vld    = |req_valid;
    assign vld_ext    = MAX_REQ'(req_valid);
    assign accept     = |(req_valid & req_ready);
    assign ptr_nxt    = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

    // Grant selection, one-hot ready strobe and operand mux.
    always_comb begin
        grant     = ID_W'(rr_pick(vld_ext, int'(rr_ptr), NUM_REQ));
        req_ready = '0;
        if (!rst && can_accept && any_vld) begin
            req_ready[grant] = 1'b1;
        end
        sq_in = req_data[SQ_IN_W*int'(grant) +: SQ_IN_W];
    end

    squares_3bit u_squares_3bit (
        .a  (sq_in),
        .sq (sq_out)
    );

    // Result register FSM: load on accept, empty on drain without a new accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= '0;
            rr_ptr    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= FULL;
                        res_valid <= 1'b1;
                        res_data  <= sq_out;
                        res_id    <= grant;
                        rr_ptr    <= ptr_nxt;
                    end
                end
                FULL: begin
                    if (accept) begin
                        res_data <= sq_out;
                        res_id   <= grant;
                        rr_ptr   <= ptr_nxt;
                    end else if (res_ready) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_square_share_arbiter.sv
// Directed scoreboard bench for square_share_arbiter (4 requesters).
// Latency: checks 1-cycle accept-to-result timing and back-to-back streaming.
// Backpressure: exercises res_ready stalls and a reset while a result is pending.
module tb_square_share_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [11:0] req_data;
    logic [3:0]  req_ready;
    logic        res_valid;
    logic [5:0]  res_data;
    logic [1:0]  res_id;
    logic        res_ready;

    int checks;
    int errors;
    logic [7:0] sb[$];

    square_share_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_ready (res_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_data(input logic [2:0] r0, input logic [2:0] r1,
                            input logic [2:0] r2, input logic [2:0] r3);
        req_data = {r3, r2, r1, r0};
    endtask

    // One cycle: check strobe and result-valid at negedge, queue the expected result.
    task automatic step(input string nm, input logic [3:0] exp_rdy, input logic exp_vld,
                        input logic [1:0] exp_id, input logic [5:0] exp_dat);
        @(negedge clk);
        chk({nm, "_ready"}, 32'(req_ready), 32'(exp_rdy));
        chk({nm, "_valid"}, 32'(res_valid), 32'(exp_vld));
        if (exp_rdy != 4'b0000) begin
            sb.push_back({exp_id, exp_dat});
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every result actually handed downstream must match the queue head.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            logic [7:0] exp;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: got id=%0d data=%0d expected none", res_id, res_data);
            end else begin
                exp = sb.pop_front();
                if ({res_id, res_data} !== exp) begin
                    errors++;
                    $display("FAIL result: got id=%0d data=%0d expected id=%0d data=%0d",
                             res_id, res_data, exp[7:6], exp[5:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        req_valid = 4'b1111;
        res_ready = 1'b1;
        set_data(3'd1, 3'd2, 3'd3, 3'd4);

        // Reset state, with requests present during reset.
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_data",  32'(res_data),  32'd0);
        chk("rst_id",    32'(res_id),    32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single request: operand 7 on requester 0 -> 49.
        req_valid = 4'b0001;
        set_data(3'd7, 3'd0, 3'd0, 3'd0);
        step("single", 4'b0001, 1'b0, 2'd0, 6'd49);
        req_valid = 4'b0000;
        step("single_lat", 4'b0000, 1'b1, 2'd0, 6'd0);

        // Boundary operands, ptr now 1: 0 -> 0, 4 -> 16, 7 -> 49.
        req_valid = 4'b0010;
        set_data(3'd0, 3'd0, 3'd4, 3'd7);
        step("zero", 4'b0010, 1'b0, 2'd1, 6'd0);
        req_valid = 4'b0100;
        step("four", 4'b0100, 1'b1, 2'd2, 6'd16);
        req_valid = 4'b1000;
        step("seven", 4'b1000, 1'b1, 2'd3, 6'd49);

        // All four requesting, ptr back at 0: grants 0,1,2,3 with no bubbles.
        set_data(3'd1, 3'd2, 3'd3, 3'd5);
        req_valid = 4'b1111;
        step("all_g0", 4'b0001, 1'b1, 2'd0, 6'd1);
        req_valid = 4'b1110;
        step("all_g1", 4'b0010, 1'b1, 2'd1, 6'd4);
        req_valid = 4'b1100;
        step("all_g2", 4'b0100, 1'b1, 2'd2, 6'd9);
        req_valid = 4'b1000;
        step("all_g3", 4'b1000, 1'b1, 2'd3, 6'd25);
        req_valid = 4'b0000;
        step("all_drain", 4'b0000, 1'b1, 2'd0, 6'd0);

        // Back-pressure: 36 from requester 1 held while res_ready is low.
        res_ready = 1'b0;
        req_valid = 4'b0010;
        set_data(3'd1, 3'd6, 3'd3, 3'd0);
        step("bp_load", 4'b0010, 1'b0, 2'd1, 6'd36);
        req_valid = 4'b0101;
        for (int i = 0; i < 5; i++) begin
            step("bp_stall", 4'b0000, 1'b1, 2'd0, 6'd0);
            chk("bp_data", 32'(res_data), 32'd36);
            chk("bp_id",   32'(res_id),   32'd1);
        end
        res_ready = 1'b1;
        step("bp_release", 4'b0100, 1'b1, 2'd2, 6'd9);
        req_valid = 4'b0001;
        step("bp_next", 4'b0001, 1'b1, 2'd0, 6'd1);
        req_valid = 4'b0000;
        step("bp_drain", 4'b0000, 1'b1, 2'd0, 6'd0);

        // Fairness wrap: move ptr to 3, then 1011 -> grants 3,0,1,3.
        req_valid = 4'b0100;
        set_data(3'd1, 3'd2, 3'd2, 3'd3);
        step("wrap_pre", 4'b0100, 1'b0, 2'd2, 6'd4);
        req_valid = 4'b1011;
        step("wrap_g3a", 4'b1000, 1'b1, 2'd3, 6'd9);
        step("wrap_g0",  4'b0001, 1'b1, 2'd0, 6'd1);
        step("wrap_g1",  4'b0010, 1'b1, 2'd1, 6'd4);
        step("wrap_g3b", 4'b1000, 1'b1, 2'd3, 6'd9);
        req_valid = 4'b0000;
        step("wrap_drain", 4'b0000, 1'b1, 2'd0, 6'd0);

        // Reset mid-operation: pending 25 from requester 2 (ptr -> 3) is discarded.
        res_ready = 1'b0;
        req_valid = 4'b0100;
        set_data(3'd1, 3'd2, 3'd5, 3'd4);
        step("mid_load", 4'b0100, 1'b0, 2'd2, 6'd25);
        rst       = 1'b1;
        req_valid = 4'b1111;
        step("mid_rst", 4'b0000, 1'b1, 2'd0, 6'd0);
        void'(sb.pop_back());
        rst       = 1'b0;
        res_ready = 1'b1;
        step("post_rst", 4'b0001, 1'b0, 2'd0, 6'd1);
        req_valid = 4'b0000;
        step("post_drain", 4'b0000, 1'b1, 2'd0, 6'd0);

        @(negedge clk);
        chk("final_idle",  32'(res_valid), 32'd0);
        chk("sb_empty",    32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
